// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for a 5-stage pipeline,
// with saturating stall-cycle and flush performance counters.
module hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned ZERO_REG     = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [2:0]       ex_writereg,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] REM_INIT = 3'(STALL_CYCLES - 1);
    localparam logic       MULTI    = (STALL_CYCLES > 1);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic [2:0] rem, rem_nxt;
    logic       hz;
    logic       zero_dst;
    logic       stall_inc;
    logic       flush_inc;

    assign zero_dst = (ZERO_REG != 0) && (ex_writereg == 3'd0);
    assign hz = ex_memread
              && ((ex_writereg == id_rs) || (id_uses_rt && (ex_writereg == id_rt)))
              && !zero_dst;

    // Mealy control outputs; reset overrides everything so X inputs cannot leak
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        busy        = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (rst) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            state_nxt   = RUN;
            rem_nxt     = 3'd0;
        end else begin
            busy = (state == STALL);
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        idex_bubble = 1'b1;
                        ifid_flush  = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (hz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        rem_nxt     = REM_INIT;
                        state_nxt   = MULTI ? STALL : RUN;
                    end
                end
                STALL: begin
                    if (ex_branch_taken) begin
                        idex_bubble = 1'b1;
                        ifid_flush  = 1'b1;
                        flush_inc   = 1'b1;
                        rem_nxt     = 3'd0;
                        state_nxt   = RUN;
                    end else if (rem != 3'd0) begin
                        // EX holds the bubble we inserted, so hz is not re-checked
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        rem_nxt     = rem - 3'd1;
                        if (rem == 3'd1) state_nxt = RUN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State and remaining-stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: four parameterisations share one input
// stream; expected per-cycle control outputs are queued and popped as sampled.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_writereg;
    logic       id_uses_rt, ex_memread, ex_branch_taken;

    logic        a_pc, a_ifw, a_bub, a_fl, a_busy;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_bub, b_fl, b_busy;
    logic [15:0] b_sc, b_fc;
    logic        z_pc, z_ifw, z_bub, z_fl, z_busy;
    logic [15:0] z_sc, z_fc;
    logic        s_pc, s_ifw, s_bub, s_fl, s_busy;
    logic [1:0]  s_sc, s_fc;

    int checks = 0;
    int failures = 0;

    logic [4:0]  exp_q [$];
    logic [11:0] stim_q [$];

    always #5 clk = ~clk;

    // a: STALL_CYCLES=1, ZERO_REG=1
    hazard_ctrl #(.STALL_CYCLES(1), .ZERO_REG(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_branch_taken(ex_branch_taken),
        .pc_write(a_pc), .ifid_write(a_ifw), .idex_bubble(a_bub), .ifid_flush(a_fl),
        .busy(a_busy), .stall_count(a_sc), .flush_count(a_fc));

    // b: STALL_CYCLES=3
    hazard_ctrl #(.STALL_CYCLES(3), .ZERO_REG(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_branch_taken(ex_branch_taken),
        .pc_write(b_pc), .ifid_write(b_ifw), .idex_bubble(b_bub), .ifid_flush(b_fl),
        .busy(b_busy), .stall_count(b_sc), .flush_count(b_fc));

    // z: ZERO_REG=0
    hazard_ctrl #(.STALL_CYCLES(1), .ZERO_REG(0), .CNT_W(16)) dut_z (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_branch_taken(ex_branch_taken),
        .pc_write(z_pc), .ifid_write(z_ifw), .idex_bubble(z_bub), .ifid_flush(z_fl),
        .busy(z_busy), .stall_count(z_sc), .flush_count(z_fc));

    // s: CNT_W=2 for saturation
    hazard_ctrl #(.STALL_CYCLES(1), .ZERO_REG(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg), .ex_branch_taken(ex_branch_taken),
        .pc_write(s_pc), .ifid_write(s_ifw), .idex_bubble(s_bub), .ifid_flush(s_fl),
        .busy(s_busy), .stall_count(s_sc), .flush_count(s_fc));

    // {pc_write, ifid_write, idex_bubble, ifid_flush, busy}
    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_HZ    = 5'b00100;
    localparam logic [4:0] O_STALL = 5'b00101;
    localparam logic [4:0] O_BR    = 5'b11110;
    localparam logic [4:0] O_BRST  = 5'b11111;
    localparam logic [4:0] O_RST   = 5'b11110;

    function automatic logic [4:0] outs(input int sel);
        case (sel)
            0: return {a_pc, a_ifw, a_bub, a_fl, a_busy};
            1: return {b_pc, b_ifw, b_bub, b_fl, b_busy};
            2: return {z_pc, z_ifw, z_bub, z_fl, z_busy};
            default: return {s_pc, s_ifw, s_bub, s_fl, s_busy};
        endcase
    endfunction

    // {rs, rt, uses_rt, memread, writereg, branch}
    function automatic logic [11:0] mk(input logic [2:0] rs, input logic [2:0] rt,
                                       input logic u, input logic m,
                                       input logic [2:0] w, input logic b);
        return {rs, rt, u, m, w, b};
    endfunction

    task automatic drive(input logic r, input logic [11:0] s);
        @(negedge clk);
        rst             = r;
        id_rs           = s[11:9];
        id_rt           = s[8:6];
        id_uses_rt      = s[5];
        ex_memread      = s[4];
        ex_writereg     = s[3:1];
        ex_branch_taken = s[0];
    endtask

    task automatic do_reset();
        drive(1'b1, 12'h000);
    endtask

    localparam logic [11:0] IDLE = 12'h000;

    task automatic test_reset();
        logic [4:0] e;
        exp_q.push_back(O_RST);
        exp_q.push_back(O_RST);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 12'hxxx);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(0) !== e || outs(1) !== e) begin
                failures++;
                $display("FAIL reset_outs: a=%b b=%b required=%b", outs(0), outs(1), e);
            end
        end
        exp_q.push_back(O_IDLE);
        drive(1'b0, IDLE);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (outs(0) !== e) begin
            failures++;
            $display("FAIL reset_idle: got=%b required=%b", outs(0), e);
        end
        @(negedge clk);
        checks++;
        if (a_sc !== 16'd0 || a_fc !== 16'd0 || b_sc !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: a_sc=%0d a_fc=%0d b_sc=%0d required=0", a_sc, a_fc, b_sc);
        end
    endtask

    task automatic test_rs_sc1();
        logic [4:0] e;
        do_reset();
        stim_q.push_back(mk(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0)); exp_q.push_back(O_HZ);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(0) !== e) begin
                failures++;
                $display("FAIL rs_sc1_outs: got=%b required=%b", outs(0), e);
            end
        end
        @(negedge clk);
        checks++;
        if (a_sc !== 16'd1) begin
            failures++;
            $display("FAIL rs_sc1_stall_count: got=%0d required=1", a_sc);
        end
    endtask

    task automatic test_rt_sc3();
        logic [4:0] e;
        do_reset();
        stim_q.push_back(mk(3'd0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0)); exp_q.push_back(O_HZ);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        stim_q.push_back(mk(3'd0, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0)); exp_q.push_back(O_IDLE);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(1) !== e) begin
                failures++;
                $display("FAIL rt_sc3_outs: got=%b required=%b", outs(1), e);
            end
        end
        @(negedge clk);
        checks++;
        if (b_sc !== 16'd3) begin
            failures++;
            $display("FAIL rt_sc3_stall_count: got=%0d required=3", b_sc);
        end
    endtask

    task automatic test_zero_reg();
        logic [4:0] e;
        do_reset();
        stim_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0)); exp_q.push_back(O_IDLE); exp_q.push_back(O_HZ);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE); exp_q.push_back(O_IDLE);
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(0) !== e) begin
                failures++;
                $display("FAIL zero_reg_on: got=%b required=%b", outs(0), e);
            end
            e = exp_q.pop_front();
            checks++;
            if (outs(2) !== e) begin
                failures++;
                $display("FAIL zero_reg_off: got=%b required=%b", outs(2), e);
            end
        end
        @(negedge clk);
        checks++;
        if (a_sc !== 16'd0 || z_sc !== 16'd1) begin
            failures++;
            $display("FAIL zero_reg_counts: a_sc=%0d z_sc=%0d required=0,1", a_sc, z_sc);
        end
    endtask

    task automatic test_branch();
        logic [4:0] e;
        do_reset();
        stim_q.push_back(mk(3'd2, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1)); exp_q.push_back(O_BR);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(0) !== e) begin
                failures++;
                $display("FAIL branch_prio_outs: got=%b required=%b", outs(0), e);
            end
        end
        @(negedge clk);
        checks++;
        if (a_fc !== 16'd1 || a_sc !== 16'd0) begin
            failures++;
            $display("FAIL branch_prio_counts: fc=%0d sc=%0d required=1,0", a_fc, a_sc);
        end
        do_reset();
        stim_q.push_back(mk(3'd4, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0)); exp_q.push_back(O_HZ);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1)); exp_q.push_back(O_BRST);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(1) !== e) begin
                failures++;
                $display("FAIL branch_abort_outs: got=%b required=%b", outs(1), e);
            end
        end
        @(negedge clk);
        checks++;
        if (b_sc !== 16'd2 || b_fc !== 16'd1) begin
            failures++;
            $display("FAIL branch_abort_counts: sc=%0d fc=%0d required=2,1", b_sc, b_fc);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        do_reset();
        stim_q.push_back(mk(3'd6, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0)); exp_q.push_back(O_HZ);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(mk(3'd1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0)); exp_q.push_back(O_HZ);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(IDLE); exp_q.push_back(O_STALL);
        stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(1) !== e) begin
                failures++;
                $display("FAIL b2b_outs: got=%b required=%b", outs(1), e);
            end
        end
        @(negedge clk);
        checks++;
        if (b_sc !== 16'd6) begin
            failures++;
            $display("FAIL b2b_stall_count: got=%0d required=6", b_sc);
        end
    endtask

    task automatic test_saturation();
        logic [4:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            stim_q.push_back(mk(3'd1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0)); exp_q.push_back(O_HZ);
            stim_q.push_back(IDLE); exp_q.push_back(O_IDLE);
        end
        for (int i = 0; i < 4; i++) begin
            stim_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1)); exp_q.push_back(O_BR);
        end
        while (stim_q.size() > 0) begin
            drive(1'b0, stim_q.pop_front());
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs(3) !== e) begin
                failures++;
                $display("FAIL sat_outs: got=%b required=%b", outs(3), e);
            end
        end
        drive(1'b0, IDLE);
        #1;
        checks++;
        if (s_sc !== 2'd3 || s_fc !== 2'd3) begin
            failures++;
            $display("FAIL sat_counts: sc=%0d fc=%0d required=3,3", s_sc, s_fc);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b0, mk(3'd2, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0));
        drive(1'b0, IDLE);
        #1;
        checks++;
        if (b_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_stall_busy: got=%b required=1", b_busy);
        end
        drive(1'b1, 12'hxxx);
        #1;
        checks++;
        if (outs(1) !== O_RST) begin
            failures++;
            $display("FAIL mid_stall_rst_outs: got=%b required=%b", outs(1), O_RST);
        end
        drive(1'b0, IDLE);
        #1;
        checks++;
        if (outs(1) !== O_IDLE || b_sc !== 16'd0 || b_fc !== 16'd0) begin
            failures++;
            $display("FAIL mid_stall_after: outs=%b sc=%0d fc=%0d required=%b,0,0",
                     outs(1), b_sc, b_fc, O_IDLE);
        end
    endtask

    initial begin
        rst = 1'b1;
        {id_rs, id_rt, id_uses_rt, ex_memread, ex_writereg, ex_branch_taken} = '0;
        test_reset();
        test_rs_sc1();
        test_rt_sc3();
        test_zero_reg();
        test_branch();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
